// File: rtl/snake_body_engine.sv
// rtl/snake_body_engine.sv - snake segment ring buffer with stepping, growth, collision and pixel query
module snake_body_engine #(
   parameter int X_W     = 8,
   parameter int Y_W     = 7,
   parameter int MAX_LEN = 64,
   parameter int SEG     = 3,
   parameter int STEP    = 2,
   parameter int X_MIN   = 5,
   parameter int X_MAX   = 153,
   parameter int Y_MIN   = 5,
   parameter int Y_MAX   = 107,
   parameter int START_X = 80,
   parameter int START_Y = 60,
   parameter bit WRAP    = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     step,
   input  logic                     dir_valid,
   input  logic [1:0]               dir_req,
   input  logic                     grow,
   input  logic [X_W-1:0]           qx,
   input  logic [Y_W-1:0]           qy,
   output logic                     q_head,
   output logic                     q_body,
   output logic [X_W-1:0]           head_x,
   output logic [Y_W-1:0]           head_y,
   output logic [$clog2(MAX_LEN):0] length,
   output logic                     busy,
   output logic                     step_done,
   output logic                     dead
);
   localparam int LW = $clog2(MAX_LEN);
   localparam logic [X_W:0]   X_MIN_E   = (X_W+1)'(X_MIN);
   localparam logic [X_W:0]   X_MAX_E   = (X_W+1)'(X_MAX);
   localparam logic [Y_W:0]   Y_MIN_E   = (Y_W+1)'(Y_MIN);
   localparam logic [Y_W:0]   Y_MAX_E   = (Y_W+1)'(Y_MAX);
   localparam logic [X_W:0]   STEP_XE   = (X_W+1)'(STEP);
   localparam logic [Y_W:0]   STEP_YE   = (Y_W+1)'(STEP);
   localparam logic [X_W:0]   SEG_XE    = (X_W+1)'(SEG-1);
   localparam logic [Y_W:0]   SEG_YE    = (Y_W+1)'(SEG-1);
   localparam logic [X_W-1:0] START_XV  = X_W'(START_X);
   localparam logic [Y_W-1:0] START_YV  = Y_W'(START_Y);
   localparam logic [LW:0]    MAX_LEN_V = (LW+1)'(MAX_LEN);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_MOVE, S_CHECK, S_DEAD} state_t;
   state_t state_q, state_d;

   // Segment i lives at index head_ptr_q + i (mod MAX_LEN); stepping moves the head backwards.
   logic [X_W-1:0] seg_x_q [MAX_LEN];
   logic [Y_W-1:0] seg_y_q [MAX_LEN];
   logic [LW-1:0]  head_ptr_q, new_ptr, chk_i_q, chk_idx;
   logic [LW:0]    len_q;
   logic [1:0]     cur_dir_q, next_dir_q;
   logic           grow_pend_q, dead_q, step_done_q, step_done_d;
   logic           q_head_q, q_body_q, q_head_d, q_body_d;
   logic [X_W:0]   x_ext;
   logic [Y_W:0]   y_ext;
   logic [X_W-1:0] new_x;
   logic [Y_W-1:0] new_y;
   logic           dec, wall_hit, move_dead, chk_match, chk_last;

   function automatic logic in_square(input logic [X_W-1:0] px, input logic [Y_W-1:0] py,
                                      input logic [X_W-1:0] sx, input logic [Y_W-1:0] sy);
      logic [X_W:0] ex;
      logic [Y_W:0] ey;
      ex = {1'b0, sx} + SEG_XE;
      ey = {1'b0, sy} + SEG_YE;
      return (px >= sx) && ({1'b0, px} <= ex) && (py >= sy) && ({1'b0, py} <= ey);
   endfunction

   assign new_ptr   = head_ptr_q - 1'b1;
   assign chk_idx   = head_ptr_q + chk_i_q;
   assign chk_match = ({1'b0, chk_i_q} < len_q) &&
                      (seg_x_q[chk_idx] == seg_x_q[head_ptr_q]) &&
                      (seg_y_q[chk_idx] == seg_y_q[head_ptr_q]);
   assign chk_last  = ({1'b0, chk_i_q} >= (len_q - 1'b1));

   // Candidate head position one step along next_dir; one extra bit catches underflow/overflow.
   always_comb begin
      x_ext = {1'b0, seg_x_q[head_ptr_q]};
      y_ext = {1'b0, seg_y_q[head_ptr_q]};
      dec   = ~next_dir_q[1];
      case (next_dir_q)
         2'b00:   y_ext = y_ext - STEP_YE;
         2'b01:   x_ext = x_ext - STEP_XE;
         2'b10:   y_ext = y_ext + STEP_YE;
         default: x_ext = x_ext + STEP_XE;
      endcase
      wall_hit = (x_ext < X_MIN_E) || (x_ext > X_MAX_E) || (y_ext < Y_MIN_E) || (y_ext > Y_MAX_E);
      new_x    = x_ext[X_W-1:0];
      new_y    = y_ext[Y_W-1:0];
      if (WRAP && wall_hit) begin
         if (next_dir_q[0]) new_x = dec ? X_MAX_E[X_W-1:0] : X_MIN_E[X_W-1:0];
         else               new_y = dec ? Y_MAX_E[Y_W-1:0] : Y_MIN_E[Y_W-1:0];
      end
      move_dead = !WRAP && wall_hit;
   end

   // Next-state logic; step_done fires only on the CHECK-to-RUN transition of a surviving step.
   always_comb begin
      state_d     = state_q;
      step_done_d = 1'b0;
      if (start) begin
         state_d = S_RUN;
      end else begin
         case (state_q)
            S_RUN:   if (step) state_d = S_MOVE;
            S_MOVE:  state_d = move_dead ? S_DEAD : S_CHECK;
            S_CHECK: begin
               if (chk_match) begin
                  state_d = S_DEAD;
               end else if (chk_last) begin
                  state_d     = S_RUN;
                  step_done_d = 1'b1;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // State register and completion pulse; reset wins over start.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         step_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_done_q <= step_done_d;
      end
   end

   // Snake body, direction, growth and collision-scan bookkeeping.
   always_ff @(posedge clk) begin
      if (!reset_n || start) begin
         head_ptr_q  <= '0;
         len_q       <= (LW+1)'(1);
         cur_dir_q   <= 2'b11;
         next_dir_q  <= 2'b11;
         grow_pend_q <= 1'b0;
         dead_q      <= 1'b0;
         chk_i_q     <= LW'(1);
         seg_x_q[0]  <= START_XV;
         seg_y_q[0]  <= START_YV;
      end else begin
         if (dir_valid && (dir_req != (cur_dir_q ^ 2'b10))) next_dir_q <= dir_req;
         if (state_q == S_MOVE) begin
            if (move_dead) begin
               dead_q <= 1'b1;
            end else begin
               head_ptr_q       <= new_ptr;
               seg_x_q[new_ptr] <= new_x;
               seg_y_q[new_ptr] <= new_y;
               cur_dir_q        <= next_dir_q;
               chk_i_q          <= LW'(1);
               if (grow_pend_q) begin
                  grow_pend_q <= 1'b0;
                  if (len_q < MAX_LEN_V) len_q <= len_q + 1'b1;
               end
            end
         end
         if (state_q == S_CHECK) begin
            if (chk_match) dead_q  <= 1'b1;
            else           chk_i_q <= chk_i_q + 1'b1;
         end
         if (grow) grow_pend_q <= 1'b1;
      end
   end

   // Pixel hit test against the registered segments; silent while IDLE.
   always_comb begin
      q_head_d = 1'b0;
      q_body_d = 1'b0;
      if (state_q != S_IDLE) begin
         q_head_d = in_square(qx, qy, seg_x_q[head_ptr_q], seg_y_q[head_ptr_q]);
         for (int i = 1; i < MAX_LEN; i++) begin
            if (((LW+1)'(i) < len_q) &&
                in_square(qx, qy, seg_x_q[head_ptr_q + LW'(i)], seg_y_q[head_ptr_q + LW'(i)]))
               q_body_d = 1'b1;
         end
      end
   end

   // Query results registered for one-cycle latency.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         q_head_q <= 1'b0;
         q_body_q <= 1'b0;
      end else begin
         q_head_q <= q_head_d;
         q_body_q <= q_body_d;
      end
   end

   assign q_head    = q_head_q;
   assign q_body    = q_body_q;
   assign head_x    = seg_x_q[head_ptr_q];
   assign head_y    = seg_y_q[head_ptr_q];
   assign length    = len_q;
   assign busy      = (state_q == S_MOVE) || (state_q == S_CHECK);
   assign step_done = step_done_q;
   assign dead      = dead_q;
endmodule

// File: tb/tb_snake_body_engine.sv
// tb/tb_snake_body_engine.sv - directed bench for snake_body_engine
module tb_snake_body_engine;
   logic       clk = 1'b0;
   logic       reset_n, start, step, dir_valid, grow;
   logic [1:0] dir_req;
   logic [7:0] qx;
   logic [6:0] qy;

   logic       q_head_a, q_body_a, busy_a, step_done_a, dead_a;
   logic       q_head_k, q_body_k, busy_k, step_done_k, dead_k;
   logic       q_head_w, q_body_w, busy_w, step_done_w, dead_w;
   logic [7:0] head_x_a, head_x_k, head_x_w;
   logic [6:0] head_y_a, head_y_k, head_y_w;
   logic [6:0] length_a, length_k;
   logic [2:0] length_w;

   int vectors = 0;
   int miscompares = 0;
   bit sd_a, sd_k, sd_w;

   always #5 clk = ~clk;

   snake_body_engine dut_a (
      .clk(clk), .reset_n(reset_n), .start(start), .step(step), .dir_valid(dir_valid),
      .dir_req(dir_req), .grow(grow), .qx(qx), .qy(qy), .q_head(q_head_a), .q_body(q_body_a),
      .head_x(head_x_a), .head_y(head_y_a), .length(length_a), .busy(busy_a),
      .step_done(step_done_a), .dead(dead_a));

   snake_body_engine #(.START_X(81)) dut_k (
      .clk(clk), .reset_n(reset_n), .start(start), .step(step), .dir_valid(dir_valid),
      .dir_req(dir_req), .grow(grow), .qx(qx), .qy(qy), .q_head(q_head_k), .q_body(q_body_k),
      .head_x(head_x_k), .head_y(head_y_k), .length(length_k), .busy(busy_k),
      .step_done(step_done_k), .dead(dead_k));

   snake_body_engine #(.START_X(81), .MAX_LEN(4), .WRAP(1'b1)) dut_w (
      .clk(clk), .reset_n(reset_n), .start(start), .step(step), .dir_valid(dir_valid),
      .dir_req(dir_req), .grow(grow), .qx(qx), .qy(qy), .q_head(q_head_w), .q_body(q_body_w),
      .head_x(head_x_w), .head_y(head_y_w), .length(length_w), .busy(busy_w),
      .step_done(step_done_w), .dead(dead_w));

   task automatic pulse_start();
      start = 1'b1; @(negedge clk); start = 1'b0;
   endtask

   task automatic pulse_grow();
      grow = 1'b1; @(negedge clk); grow = 1'b0;
   endtask

   task automatic set_dir(input logic [1:0] d);
      dir_valid = 1'b1; dir_req = d; @(negedge clk); dir_valid = 1'b0;
   endtask

   task automatic do_step();
      int c;
      c = 0;
      sd_a = 1'b0; sd_k = 1'b0; sd_w = 1'b0;
      step = 1'b1; @(negedge clk); step = 1'b0;
      while ((busy_a || busy_k || busy_w) && c < 100) begin
         @(negedge clk);
         c++;
         sd_a |= step_done_a; sd_k |= step_done_k; sd_w |= step_done_w;
      end
      vectors++;
      if (c >= 100) begin miscompares++; $display("FAIL step_timeout busy after %0d cycles, required idle", c); end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; qx = 8'd80; qy = 7'd60;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      vectors++; if (head_x_a !== 8'd80) begin miscompares++; $display("FAIL rst_head_x got %0d exp 80", head_x_a); end
      vectors++; if (head_y_a !== 7'd60) begin miscompares++; $display("FAIL rst_head_y got %0d exp 60", head_y_a); end
      vectors++; if (length_a !== 7'd1) begin miscompares++; $display("FAIL rst_length got %0d exp 1", length_a); end
      vectors++; if ({busy_a, dead_a, step_done_a} !== 3'b000) begin miscompares++; $display("FAIL rst_flags got %b exp 000", {busy_a, dead_a, step_done_a}); end
      vectors++; if (q_head_a !== 1'b0) begin miscompares++; $display("FAIL idle_q_head got %b exp 0", q_head_a); end
      pulse_start();
      vectors++; if ({head_x_a, head_y_a} !== {8'd80, 7'd60}) begin miscompares++; $display("FAIL start_head got %0d,%0d exp 80,60", head_x_a, head_y_a); end
      vectors++; if ({busy_a, dead_a, length_a} !== {1'b0, 1'b0, 7'd1}) begin miscompares++; $display("FAIL start_state got b%b d%b l%0d exp 0 0 1", busy_a, dead_a, length_a); end
      @(negedge clk);
      vectors++; if ({q_head_a, q_body_a} !== 2'b10) begin miscompares++; $display("FAIL run_query got %b exp 10", {q_head_a, q_body_a}); end
   endtask

   task automatic test_step_latency();
      for (int k = 0; k < 3; k++) begin
         step = 1'b1; @(negedge clk); step = 1'b0;
         vectors++; if ({busy_a, step_done_a} !== 2'b10) begin miscompares++; $display("FAIL lat_move step %0d got %b exp 10", k, {busy_a, step_done_a}); end
         @(negedge clk);
         vectors++; if (step_done_a !== 1'b0) begin miscompares++; $display("FAIL lat_check step %0d got %b exp 0", k, step_done_a); end
         @(negedge clk);
         vectors++; if ({busy_a, step_done_a} !== 2'b01) begin miscompares++; $display("FAIL lat_done step %0d got %b exp 01", k, {busy_a, step_done_a}); end
         vectors++; if (head_x_a !== 8'(82 + 2*k)) begin miscompares++; $display("FAIL lat_head_x got %0d exp %0d", head_x_a, 82 + 2*k); end
         @(negedge clk);
         vectors++; if (step_done_a !== 1'b0) begin miscompares++; $display("FAIL lat_pulse step %0d got %b exp 0", k, step_done_a); end
      end
   endtask

   task automatic test_step_dropped();
      step = 1'b1; repeat (3) @(negedge clk); step = 1'b0;
      repeat (2) @(negedge clk);
      vectors++; if (head_x_a !== 8'd88) begin miscompares++; $display("FAIL drop_head_x got %0d exp 88", head_x_a); end
      vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL drop_busy got %b exp 0", busy_a); end
   endtask

   task automatic test_grow_dir();
      pulse_grow();
      set_dir(2'b00);
      do_step();
      vectors++; if ({head_y_a, length_a} !== {7'd58, 7'd2}) begin miscompares++; $display("FAIL grow_first got y%0d l%0d exp y58 l2", head_y_a, length_a); end
      do_step();
      set_dir(2'b10);
      do_step();
      do_step();
      vectors++; if ({head_x_a, head_y_a} !== {8'd88, 7'd52}) begin miscompares++; $display("FAIL reverse_head got %0d,%0d exp 88,52", head_x_a, head_y_a); end
      vectors++; if ({length_a, dead_a} !== {7'd2, 1'b0}) begin miscompares++; $display("FAIL grow_len got l%0d d%b exp l2 d0", length_a, dead_a); end
   endtask

   task automatic test_uturn();
      pulse_start();
      for (int k = 0; k < 4; k++) begin
         pulse_grow();
         do_step();
      end
      vectors++; if (length_a !== 7'd5) begin miscompares++; $display("FAIL grow_to5 got %0d exp 5", length_a); end
      vectors++; if (length_w !== 3'd4) begin miscompares++; $display("FAIL grow_saturate got %0d exp 4", length_w); end
      set_dir(2'b00); do_step();
      set_dir(2'b01); do_step();
      set_dir(2'b10); do_step();
      vectors++; if ({dead_a, sd_a} !== 2'b10) begin miscompares++; $display("FAIL self_hit got dead%b done%b exp 10", dead_a, sd_a); end
      vectors++; if ({head_x_a, head_y_a} !== {8'd86, 7'd60}) begin miscompares++; $display("FAIL self_head got %0d,%0d exp 86,60", head_x_a, head_y_a); end
      vectors++; if ({dead_w, sd_w, dead_k} !== 3'b011) begin miscompares++; $display("FAIL short_alive got %b exp 011", {dead_w, sd_w, dead_k}); end
      qx = 8'd88; qy = 7'd60; @(negedge clk);
      vectors++; if ({q_head_a, q_body_a} !== 2'b11) begin miscompares++; $display("FAIL query_head got %b exp 11", {q_head_a, q_body_a}); end
      qx = 8'd89; @(negedge clk);
      vectors++; if ({q_head_a, q_body_a} !== 2'b01) begin miscompares++; $display("FAIL query_edge got %b exp 01", {q_head_a, q_body_a}); end
      qx = 8'd80; @(negedge clk);
      vectors++; if ({q_head_a, q_body_a} !== 2'b00) begin miscompares++; $display("FAIL query_stale got %b exp 00", {q_head_a, q_body_a}); end
   endtask

   task automatic test_wall();
      pulse_start();
      for (int k = 0; k < 36; k++) do_step();
      vectors++; if ({head_x_k, dead_k} !== {8'd153, 1'b0}) begin miscompares++; $display("FAIL wall_edge_r got x%0d d%b exp x153 d0", head_x_k, dead_k); end
      do_step();
      vectors++; if ({dead_k, sd_k, dead_a} !== 3'b101) begin miscompares++; $display("FAIL wall_kill_r got %b exp 101", {dead_k, sd_k, dead_a}); end
      vectors++; if ({head_x_w, dead_w, sd_w} !== {8'd5, 1'b0, 1'b1}) begin miscompares++; $display("FAIL wrap_r got x%0d d%b s%b exp x5 d0 s1", head_x_w, dead_w, sd_w); end
      pulse_start();
      vectors++; if ({dead_k, dead_a, head_x_k} !== {1'b0, 1'b0, 8'd81}) begin miscompares++; $display("FAIL start_clear got %b%b x%0d exp 00 x81", dead_k, dead_a, head_x_k); end
      set_dir(2'b00); do_step();
      set_dir(2'b01);
      for (int k = 0; k < 38; k++) do_step();
      vectors++; if ({head_x_k, dead_k} !== {8'd5, 1'b0}) begin miscompares++; $display("FAIL wall_edge_l got x%0d d%b exp x5 d0", head_x_k, dead_k); end
      do_step();
      vectors++; if (dead_k !== 1'b1) begin miscompares++; $display("FAIL wall_kill_l got %b exp 1", dead_k); end
      vectors++; if ({head_x_w, dead_w} !== {8'd153, 1'b0}) begin miscompares++; $display("FAIL wrap_l got x%0d d%b exp x153 d0", head_x_w, dead_w); end
   endtask

   task automatic test_reset_mid_check();
      pulse_start();
      step = 1'b1; @(negedge clk); step = 1'b0;
      @(negedge clk);
      vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL mid_busy got %b exp 1", busy_a); end
      reset_n = 1'b0;
      @(negedge clk);
      vectors++; if ({step_done_a, busy_a} !== 2'b00) begin miscompares++; $display("FAIL mid_abort got %b exp 00", {step_done_a, busy_a}); end
      vectors++; if ({head_x_a, length_a} !== {8'd80, 7'd1}) begin miscompares++; $display("FAIL mid_head got x%0d l%0d exp x80 l1", head_x_a, length_a); end
      reset_n = 1'b1;
      @(negedge clk);
      vectors++; if (step_done_a !== 1'b0) begin miscompares++; $display("FAIL mid_after got %b exp 0", step_done_a); end
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; step = 1'b0; dir_valid = 1'b0; dir_req = 2'b11; grow = 1'b0;
      qx = '0; qy = '0;
      @(negedge clk);
      test_reset();
      test_step_latency();
      test_step_dropped();
      test_grow_dir();
      test_uturn();
      test_wall();
      test_reset_mid_check();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
